// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_mp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 16;

endpackage

// File: rtl/regfile_mp_sweep.sv
// Flush sequencer: walks a pointer over every register once, issuing a clearing
// write per cycle, and reports Busy for exactly DEPTH cycles.
module regfile_mp_sweep
  import regfile_mp_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          flush,
  output logic          busy,
  output logic          sweep_we,
  output logic [AW-1:0] sweep_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_reg, state_next;
  logic [AW-1:0] ptr_reg, ptr_next;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Flush is only looked at in IDLE, so a repeat request cannot stretch a sweep.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (flush) begin
          state_next = SWEEP;
          ptr_next   = '0;
        end
      end
      SWEEP: begin
        ptr_next = ptr_reg + 1'b1;
        if (ptr_reg == LAST_ADDR) begin
          state_next = IDLE;
          ptr_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  assign busy       = (state_reg == SWEEP);
  assign sweep_we   = busy;
  assign sweep_addr = ptr_reg;

endmodule

// File: rtl/regfile_mp.sv
// Register file with two combinational read ports, one write port and a flush sweep.
// Optional write-to-read forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int DEPTH   = DEF_DEPTH,
  parameter  int ZERO_R0 = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             Clear_n,
  input  logic [AW-1:0]    Aaddr,
  input  logic [AW-1:0]    Baddr,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [AW-1:0]    Caddr,
  input  logic [WIDTH-1:0] C,
  input  logic             Load,
  input  logic             Flush,
  output logic             Busy
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             busy;
  logic             sweep_we;
  logic [AW-1:0]    sweep_addr;
  logic             write_en;
  logic             r0_blocked;

  regfile_mp_sweep #(
    .DEPTH(DEPTH)
  ) u_sweep (
    .clk       (clk),
    .clear_n   (Clear_n),
    .flush     (Flush),
    .busy      (busy),
    .sweep_we  (sweep_we),
    .sweep_addr(sweep_addr)
  );

  assign Busy       = busy;
  assign write_en   = Load && !busy;
  assign r0_blocked = (ZERO_R0 != 0) && (Caddr == '0);

  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (sweep_we) begin
      mem_reg[sweep_addr] <= '0;
    end else if (write_en && !r0_blocked) begin
      mem_reg[Caddr] <= C;
    end
  end

  // The hard-wired zero for register 0 is applied last so it also overrides forwarding.
  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] d;
    d = mem_reg[addr];
`ifdef REGFILE_MP_BYPASS_EN
    if (write_en && (Caddr == addr)) d = C;
`endif
    if ((ZERO_R0 != 0) && (addr == '0)) d = '0;
    return d;
  endfunction

  assign A = read_port(Aaddr);
  assign B = read_port(Baddr);

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a plain array model predicts both read ports
// and Busy each cycle; a negedge monitor pops and compares.
module tb_regfile_mp;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;
`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          clear_n;
  logic          load;
  logic          flush;
  logic [AW-1:0] aaddr, baddr, caddr;
  logic [W-1:0]  c;
  logic [W-1:0]  a0, b0, a1, b1;
  logic          busy0, busy1;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .ZERO_R0(0)) u_dut (
    .clk(clk), .Clear_n(clear_n), .Aaddr(aaddr), .Baddr(baddr), .A(a0), .B(b0),
    .Caddr(caddr), .C(c), .Load(load), .Flush(flush), .Busy(busy0)
  );

  regfile_mp #(.WIDTH(W), .DEPTH(D), .ZERO_R0(1)) u_dut_zr (
    .clk(clk), .Clear_n(clear_n), .Aaddr(aaddr), .Baddr(baddr), .A(a1), .B(b1),
    .Caddr(caddr), .C(c), .Load(load), .Flush(flush), .Busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int           id;
    logic [W-1:0] a0, b0, a1, b1;
    logic         busy;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  int           txn = 0;
  logic [W-1:0] model [D];
  int           sweep_left = 0;
  int           sweep_ptr = 0;

  function automatic logic [W-1:0] exp_read(input logic [AW-1:0] addr, input bit zr);
    if (zr && addr == 0) return '0;
    if (BYP && load && sweep_left == 0 && caddr == addr) return c;
    return model[addr];
  endfunction

  // One clock of stimulus: drive, predict, push, then advance the model at the edge.
  task automatic step(input bit ld, input logic [AW-1:0] ca, input logic [W-1:0] cv,
                      input bit fl, input logic [AW-1:0] aa, input logic [AW-1:0] ba);
    exp_t e;
    load = ld; caddr = ca; c = cv; flush = fl; aaddr = aa; baddr = ba;
    if (!clear_n) begin
      for (int i = 0; i < D; i++) model[i] = '0;
      sweep_left = 0;
      sweep_ptr  = 0;
    end
    e.id   = txn;
    e.a0   = exp_read(aa, 1'b0);
    e.b0   = exp_read(ba, 1'b0);
    e.a1   = exp_read(aa, 1'b1);
    e.b1   = exp_read(ba, 1'b1);
    e.busy = (sweep_left > 0);
    sb_q.push_back(e);
    $display("TXN %0d rst_n=%0b ld=%0b ca=%0d c=%h fl=%0b aa=%0d ba=%0d exp_busy=%0b",
             txn, clear_n, ld, ca, cv, fl, aa, ba, e.busy);
    @(posedge clk);
    if (clear_n) begin
      if (sweep_left > 0) begin
        model[sweep_ptr] = '0;
        sweep_ptr++;
        sweep_left--;
      end else begin
        if (ld) model[ca] = cv;
        if (fl) begin
          sweep_left = D;
          sweep_ptr  = 0;
        end
      end
    end
    #1;
    txn++;
  endtask

  task automatic chk(input string name, input int id, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s txn %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("A", e.id, a0, e.a0);
        chk("B", e.id, b0, e.b0);
        chk("A_zr", e.id, a1, e.a1);
        chk("B_zr", e.id, b1, e.b1);
        chk("Busy", e.id, W'(busy0), W'(e.busy));
        chk("Busy_zr", e.id, W'(busy1), W'(e.busy));
      end
    end
  end

  task automatic read_all();
    for (int i = 0; i < D; i++) step(1'b0, '0, '0, 1'b0, AW'(i), AW'(D - 1 - i));
  endtask

  task automatic fill_all();
    for (int i = 0; i < D; i++)
      step(1'b1, AW'(i), W'($urandom) | 16'h0001, 1'b0, AW'(i), AW'($urandom_range(0, D - 1)));
  endtask

  task automatic drain_sweep();
    while (sweep_left > 0)
      step(1'b0, '0, '0, 1'b0, AW'($urandom_range(0, D - 1)), AW'($urandom_range(0, D - 1)));
  endtask

  initial begin
    clear_n = 1'b0; load = 1'b0; flush = 1'b0;
    aaddr = '0; baddr = '0; caddr = '0; c = '0;
    for (int i = 0; i < D; i++) model[i] = '0;
    @(posedge clk);
    #1;
    // Reset state and post-release reads
    step(1'b0, '0, '0, 1'b0, 4'd3, 4'd9);
    step(1'b0, '0, '0, 1'b1, 4'd0, 4'd15);
    clear_n = 1'b1;
    read_all();
    // Directed write/read and forwarding cases
    step(1'b1, 4'd5, 16'h1234, 1'b0, 4'd5, 4'd6);
    step(1'b0, '0, '0, 1'b0, 4'd5, 4'd6);
    step(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd3, 4'd3);
    step(1'b0, '0, '0, 1'b0, 4'd3, 4'd5);
    step(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 4'd0);
    step(1'b0, '0, '0, 1'b0, 4'd0, 4'd5);
    // Randomized traffic with occasional flushes
    for (int n = 0; n < 200; n++) begin
      logic [AW-1:0] ca;
      ca = AW'($urandom_range(0, D - 1));
      step(1'($urandom_range(0, 1)), ca, W'($urandom), ($urandom_range(0, 39) == 0),
           $urandom_range(0, 1) ? ca : AW'($urandom_range(0, D - 1)),
           $urandom_range(0, 1) ? ca : AW'($urandom_range(0, D - 1)));
    end
    drain_sweep();
    // Full sweep with a dropped write and a repeated flush inside it
    fill_all();
    step(1'b0, '0, '0, 1'b1, 4'd15, 4'd0);
    for (int k = 0; k < D; k++)
      step(k == 3, 4'd15, 16'hAAAA, k == 5, AW'(k), 4'd15);
    read_all();
    // Load and Flush together in IDLE
    step(1'b1, 4'd7, 16'h5A5A, 1'b1, 4'd7, 4'd7);
    step(1'b0, '0, '0, 1'b0, 4'd7, 4'd7);
    drain_sweep();
    read_all();
    // Reset at sweep cycle 7
    fill_all();
    step(1'b0, '0, '0, 1'b1, 4'd1, 4'd2);
    for (int k = 0; k < 7; k++) step(1'b0, '0, '0, 1'b0, AW'(k), 4'd12);
    clear_n = 1'b0;
    step(1'b0, '0, '0, 1'b0, 4'd12, 4'd13);
    clear_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b0, 4'd14, 4'd15);
    read_all();
    // Let the monitor drain
    for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of registers, power of two, minimum 2.
REQ-003 SHALL have parameter ZERO_R0, default 0; when 1, register 0 reads as zero and ignores writes.
REQ-004 SHALL derive localparam AW = clog2(DEPTH) and use it for all address widths.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Clear_n  input  1  reset, asynchronous, active-low.
REQ-007 Aaddr  input  AW  read port A address.
REQ-008 Baddr  input  AW  read port B address.
REQ-009 A  output  WIDTH  read port A data.
REQ-010 B  output  WIDTH  read port B data.
REQ-011 Caddr  input  AW  write port address.
REQ-012 C  input  WIDTH  write port data.
REQ-013 Load  input  1  write enable for port C.
REQ-014 Flush  input  1  single-cycle request to sweep-clear all registers.
REQ-015 Busy  output  1  high while a sweep is in progress.

Function
REQ-016 Reads SHALL be combinational: A = reg[Aaddr], B = reg[Baddr], zero cycles latency.
REQ-017 With Load=1, Busy=0, reg[Caddr] SHALL take C at the next rising clk edge.
REQ-018 Ports A and B SHALL read the same address simultaneously and independently.
REQ-019 The FSM SHALL have states IDLE and SWEEP; reset state is IDLE.
REQ-020 In IDLE, Flush=1 SHALL move to SWEEP at the next edge with sweep pointer = 0.
REQ-021 In SWEEP, each cycle SHALL write 0 to reg[pointer] and then increment the pointer.
REQ-022 Once the write of reg[DEPTH-1] completes, the FSM SHALL return to IDLE, taking exactly DEPTH cycles in SWEEP.
REQ-023 Busy SHALL equal (state == SWEEP), registered, and SHALL be 0 in IDLE.
REQ-024 Load SHALL be ignored while Busy=1; a dropped write SHALL have no effect on any register.
REQ-025 Flush SHALL be ignored while Busy=1; it SHALL neither restart nor extend the sweep.
REQ-026 Flush and Load asserted together in IDLE: the write SHALL commit at that edge, and the sweep SHALL start next cycle and clear it.
REQ-027 Reads during SWEEP SHALL return 0 for already-cleared entries and old contents for the rest.
REQ-028 With ZERO_R0=1, A or B addressing 0 SHALL read 0 under all conditions, including bypass.

Reset
REQ-029 Clear_n low SHALL, asynchronously, clear every register to 0, force state to IDLE, pointer to 0 and Busy to 0.
REQ-030 Clear_n asserted mid-sweep SHALL abort the sweep; no sweep SHALL resume after release.
REQ-031 After Clear_n release, A and B SHALL read 0 for every address until written.

Configuration
REQ-032 Macro REGFILE_MP_BYPASS_EN SHALL control write-to-read forwarding.
REQ-033 With REGFILE_MP_BYPASS_EN defined: when Load=1, Busy=0 and Caddr equals Aaddr (or Baddr), A (or B) SHALL show C in the same cycle.
REQ-034 With REGFILE_MP_BYPASS_EN undefined: reads SHALL show stored contents only; the new value SHALL appear the cycle after the write.

Structure
REQ-035 Package regfile_mp_pkg SHALL hold the FSM state enum (IDLE, SWEEP) and the default WIDTH and DEPTH constants.
REQ-036 Sub-module regfile_mp_sweep SHALL contain the FSM, the pointer counter and Busy, and SHALL export the sweep write enable and address.

Verification
REQ-037 Reset, write 0x1234 to reg 5, read Aaddr=5 the next cycle -> A=0x1234; B on Baddr=6 -> 0x0000.
REQ-038 Bypass build: Load=1, Caddr=3, C=0xBEEF, Aaddr=3 -> A=0xBEEF in the same cycle; non-bypass build -> A=old value, then 0xBEEF next cycle.
REQ-039 Fill all 16 registers, pulse Flush -> Busy high exactly 16 cycles; every register reads 0 after Busy falls.
REQ-040 During the sweep, Load=1, Caddr=15, C=0xAAAA -> after the sweep, reg 15 = 0; a second Flush pulse mid-sweep -> Busy duration still 16.
REQ-041 Drop Clear_n at sweep cycle 7 -> Busy=0 and all registers=0 immediately; no sweep resumes after release.
REQ-042 ZERO_R0=1: write 0xFFFF to reg 0 -> A with Aaddr=0 reads 0x0000, in both bypass and non-bypass builds.
